// File: rtl/cmd_dispatch.sv
// -----------------------------------------------------------------------------
// cmd_dispatch
//
// Command front end for the pdh_core sub-blocks. A 32-bit command word is
// handed over from the PS with a toggle strobe. Each level change of the strobe
// is one command. The opcode selects a target. That target receives a one-cycle
// enable plus the payload. After a fixed settle time, the target's callback is
// captured into a status word that the PS reads back.
//
// Ports
//   clk          in   1                          system clock
//   rst_n        in   1                          synchronous, active-low reset
//   cmd_word_i   in   32                         [31:28] opcode, [27:0] payload
//   cmd_strobe_i in   1                          toggle strobe, one command per level change
//   callback_i   in   N_TARGETS*CALLBACK_WIDTH   callback of target k at slice k
//   en_o         out  N_TARGETS                  one-hot, one-cycle enable to the addressed target
//   data_o       out  DATA_WIDTH                 payload, held from accept until the next accept
//   status_o     out  32                         [7:0] cb, [11:8] opcode, [12] done, [13] err,
//                                                [14] overrun, [15] busy, [31:16] sequence count
// -----------------------------------------------------------------------------
module cmd_dispatch #(
    parameter int N_TARGETS      = 4,
    parameter int DATA_WIDTH     = 8,
    parameter int CALLBACK_WIDTH = 8,
    parameter int SETTLE_CYCLES  = 6
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [31:0]                         cmd_word_i,
    input  logic                                cmd_strobe_i,
    input  logic [N_TARGETS*CALLBACK_WIDTH-1:0] callback_i,
    output logic [N_TARGETS-1:0]                en_o,
    output logic [DATA_WIDTH-1:0]               data_o,
    output logic [31:0]                         status_o
);

    localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT    = 2'd2,
        ST_CAPTURE = 2'd3
    } state_t;

    state_t                     state_r;
    logic                       tog_r;
    logic [3:0]                 op_r;
    logic [CNT_W-1:0]           cnt_r;
    logic [N_TARGETS-1:0]       en_r;
    logic [DATA_WIDTH-1:0]      data_r;
    logic [7:0]                 cb_r;
    logic                       done_r;
    logic                       err_r;
    logic                       ovr_r;
    logic                       busy_r;
    logic [15:0]                seq_r;

    logic                       toggle_s;
    logic                       op_valid_s;
    logic [3:0]                 sel_s;
    logic [CALLBACK_WIDTH-1:0]  slice_s;
    logic [31:0]                cb_ext_s;
    logic [7:0]                 cb_sel_s;
    logic                       unused_s;

    // One-hot decode of a target index into the enable vector.
    function automatic logic [N_TARGETS-1:0] onehot(input logic [3:0] idx);
        logic [N_TARGETS-1:0] v;
        v = {N_TARGETS{1'b0}};
        for (int i = 0; i < N_TARGETS; i++) begin
            if (idx == i[3:0]) begin
                v[i] = 1'b1;
            end else begin
                v[i] = 1'b0;
            end
        end
        return v;
    endfunction

    assign toggle_s   = cmd_strobe_i ^ tog_r;
    assign op_valid_s = ({1'b0, op_r} < 5'(N_TARGETS));

    // Select the addressed target's callback and zero-extend it to the 8-bit status field.
    // An out-of-range opcode is steered to slice 0 so the part-select stays in range;
    // its value is never captured in that case.
    always_comb begin
        sel_s    = 4'd0;
        if (op_valid_s) begin
            sel_s = op_r;
        end else begin
            sel_s = 4'd0;
        end
        slice_s  = callback_i[sel_s*CALLBACK_WIDTH +: CALLBACK_WIDTH];
        cb_ext_s = 32'(slice_s);
        cb_sel_s = cb_ext_s[7:0];
    end

    // Payload bits above DATA_WIDTH and the upper callback extension are intentionally unused.
    assign unused_s = ^{cmd_word_i[27:DATA_WIDTH], cb_ext_s[31:8]};

    // Command FSM: accept, issue the enable, settle, capture. Also provides overrun tracking.
    // Timing: the enable is registered on the ISSUE->WAIT edge. WAIT then spans
    // SETTLE_CYCLES+1 cycles (the counter counts SETTLE_CYCLES down to zero, then exits).
    // As a result, done rises SETTLE_CYCLES+3 edges after the accept edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            tog_r   <= cmd_strobe_i;
            op_r    <= 4'd0;
            cnt_r   <= {CNT_W{1'b0}};
            en_r    <= {N_TARGETS{1'b0}};
            data_r  <= {DATA_WIDTH{1'b0}};
            cb_r    <= 8'd0;
            done_r  <= 1'b0;
            err_r   <= 1'b0;
            ovr_r   <= 1'b0;
            busy_r  <= 1'b0;
            seq_r   <= 16'd0;
        end else begin
            en_r <= {N_TARGETS{1'b0}};

            // A toggle that arrives while busy is dropped. The strobe is resynchronised so
            // the dropped command is not replayed once the FSM returns to IDLE.
            if ((state_r != ST_IDLE) && toggle_s) begin
                ovr_r <= 1'b1;
                tog_r <= cmd_strobe_i;
            end

            case (state_r)
                ST_IDLE: begin
                    if (toggle_s) begin
                        tog_r   <= cmd_strobe_i;
                        op_r    <= cmd_word_i[31:28];
                        data_r  <= cmd_word_i[DATA_WIDTH-1:0];
                        busy_r  <= 1'b1;
                        done_r  <= 1'b0;
                        err_r   <= 1'b0;
                        ovr_r   <= 1'b0;
                        state_r <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (op_valid_s) begin
                        en_r    <= onehot(op_r);
                        cnt_r   <= CNT_W'(SETTLE_CYCLES);
                        state_r <= ST_WAIT;
                    end else begin
                        err_r   <= 1'b1;
                        cb_r    <= 8'd0;
                        state_r <= ST_CAPTURE;
                    end
                end
                ST_WAIT: begin
                    if (cnt_r == {CNT_W{1'b0}}) begin
                        state_r <= ST_CAPTURE;
                    end else begin
                        cnt_r <= cnt_r - CNT_W'(1);
                    end
                end
                ST_CAPTURE: begin
                    if (!err_r) begin
                        cb_r <= cb_sel_s;
                    end
                    done_r  <= 1'b1;
                    busy_r  <= 1'b0;
                    seq_r   <= seq_r + 16'd1;
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign en_o     = en_r;
    assign data_o   = data_r;
    assign status_o = {seq_r, busy_r, ovr_r, err_r, done_r, op_r, cb_r};

endmodule

// File: tb/tb_cmd_dispatch.sv
// -----------------------------------------------------------------------------
// tb_cmd_dispatch
//
// Self-checking bench for cmd_dispatch. It uses directed vectors and randomised
// commands. Expected status words, latencies and enable pulses come from a small
// rule-based model of the command protocol.
// -----------------------------------------------------------------------------
module tb_cmd_dispatch;

    localparam int NT = 4;
    localparam int DW = 8;
    localparam int CW = 8;
    localparam int SC = 6;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] cmd_word;
    logic        cmd_strobe;
    logic [31:0] callback;
    logic [3:0]  en;
    logic [7:0]  data;
    logic [31:0] status;

    int total_cnt = 0;
    int bad_cnt   = 0;

    logic [15:0] model_seq;

    // observations gathered by send_cmd
    int          obs_en_cnt;
    logic [3:0]  obs_en_val;
    int          obs_done_k;
    logic [31:0] obs_status;
    int          obs_data_bad;
    logic [31:0] obs_status0;

    cmd_dispatch #(
        .N_TARGETS      (NT),
        .DATA_WIDTH     (DW),
        .CALLBACK_WIDTH (CW),
        .SETTLE_CYCLES  (SC)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd_word_i   (cmd_word),
        .cmd_strobe_i (cmd_strobe),
        .callback_i   (callback),
        .en_o         (en),
        .data_o       (data),
        .status_o     (status)
    );

    always #5 clk = ~clk;

    // Reference: final status word a command must leave behind.
    function automatic logic [31:0] exp_status(input logic [31:0] word, input logic [31:0] cbv,
                                               input logic [15:0] seq, input logic ovr);
        int         op;
        logic [7:0] cb;
        logic       err;
        op  = int'(word[31:28]);
        err = (op >= NT);
        cb  = err ? 8'h00 : cbv[op*8 +: 8];
        return {seq, 1'b0, ovr, err, 1'b1, word[31:28], cb};
    endfunction

    // Reference: number of edges from accept to done.
    function automatic int exp_latency(input logic [31:0] word);
        return (int'(word[31:28]) < NT) ? SC + 3 : 2;
    endfunction

    // Drive one command and record what the DUT does. The first sample (k=0) follows
    // the accept edge. tog2_at >= 0 re-toggles the strobe after sample k.
    task automatic send_cmd(input logic [31:0] word, input logic [31:0] cbv, input int tog2_at);
        obs_en_cnt   = 0;
        obs_en_val   = 4'b0000;
        obs_done_k   = -1;
        obs_data_bad = 0;
        obs_status   = 32'h0;
        obs_status0  = 32'h0;
        @(negedge clk);
        cmd_word   = word;
        callback   = cbv;
        cmd_strobe = ~cmd_strobe;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            if (k == 0) obs_status0 = status;
            if (en !== 4'b0000) begin
                obs_en_cnt++;
                obs_en_val = en;
            end
            if (data !== word[7:0]) obs_data_bad++;
            if (obs_done_k < 0 && status[12] === 1'b1) begin
                obs_done_k = k;
                obs_status = status;
            end
            if (k == tog2_at) cmd_strobe = ~cmd_strobe;
            if (obs_done_k >= 0 && k >= obs_done_k + 3) break;
        end
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        cmd_strobe = 1'b1;
        cmd_word   = 32'h0;
        callback   = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            total_cnt++;
            if (en !== 4'b0000 || status !== 32'h0 || data !== 8'h00) begin
                bad_cnt++;
                $display("FAIL reset_idle cycle %0d: en=%b status=%h data=%h, required en=0000 status=00000000 data=00",
                         i, en, status, data);
            end
        end
        model_seq = 16'd0;
    endtask

    task automatic test_target0();
        logic [31:0] cbv;
        cbv = ($urandom() & 32'hFFFF_FF00) | 32'h0000_00A5;
        send_cmd(32'h0000_00A5, cbv, -1);
        model_seq++;
        total_cnt++;
        if (obs_en_cnt !== 1 || obs_en_val !== 4'b0001) begin
            bad_cnt++;
            $display("FAIL t0_enable: pulses=%0d en=%b, required pulses=1 en=0001", obs_en_cnt, obs_en_val);
        end
        total_cnt++;
        if (obs_done_k !== SC + 3) begin
            bad_cnt++;
            $display("FAIL t0_latency: done at edge %0d, required %0d", obs_done_k, SC + 3);
        end
        total_cnt++;
        if (obs_status !== 32'h0001_10A5) begin
            bad_cnt++;
            $display("FAIL t0_status: got %h, required 000110a5", obs_status);
        end
        total_cnt++;
        if (obs_data_bad !== 0) begin
            bad_cnt++;
            $display("FAIL t0_data: %0d samples differ from a5 (last data=%h)", obs_data_bad, data);
        end
    endtask

    task automatic test_target3();
        logic [31:0] cbv;
        cbv = ($urandom() & 32'h00FF_FFFF) | 32'h3C00_0000;
        send_cmd(32'h3000_0042, cbv, -1);
        model_seq++;
        total_cnt++;
        if (obs_en_cnt !== 1 || obs_en_val !== 4'b1000) begin
            bad_cnt++;
            $display("FAIL t3_enable: pulses=%0d en=%b, required pulses=1 en=1000", obs_en_cnt, obs_en_val);
        end
        total_cnt++;
        if (obs_status !== 32'h0002_133C) begin
            bad_cnt++;
            $display("FAIL t3_status: got %h, required 0002133c", obs_status);
        end
    endtask

    task automatic test_invalid();
        send_cmd(32'h9000_0011, $urandom(), -1);
        model_seq++;
        total_cnt++;
        if (obs_en_cnt !== 0) begin
            bad_cnt++;
            $display("FAIL inv_enable: pulses=%0d, required 0", obs_en_cnt);
        end
        total_cnt++;
        if (obs_done_k !== 2) begin
            bad_cnt++;
            $display("FAIL inv_latency: done at edge %0d, required 2", obs_done_k);
        end
        total_cnt++;
        if (obs_status !== 32'h0003_3900) begin
            bad_cnt++;
            $display("FAIL inv_status: got %h, required 00033900", obs_status);
        end
        total_cnt++;
        if (obs_data_bad !== 0) begin
            bad_cnt++;
            $display("FAIL inv_data: %0d samples differ from 11", obs_data_bad);
        end
    endtask

    // Second toggle mid-command, then a toggle exactly on the capture edge. Each is
    // followed by a clean command that must clear overrun.
    task automatic test_overrun();
        logic [31:0] word;
        logic [31:0] cbv;
        int          tog_points [2];
        tog_points[0] = 1;
        tog_points[1] = SC + 2;
        for (int t = 0; t < 2; t++) begin
            word = {2'b00, 2'($urandom_range(0, 3)), 28'($urandom())};
            cbv  = $urandom();
            send_cmd(word, cbv, tog_points[t]);
            model_seq++;
            total_cnt++;
            if (obs_en_cnt !== 1) begin
                bad_cnt++;
                $display("FAIL ovr_single_pulse[%0d]: pulses=%0d, required 1", t, obs_en_cnt);
            end
            total_cnt++;
            if (obs_status !== exp_status(word, cbv, model_seq, 1'b1)) begin
                bad_cnt++;
                $display("FAIL ovr_status[%0d]: got %h, required %h", t, obs_status,
                         exp_status(word, cbv, model_seq, 1'b1));
            end
            word = {2'b00, 2'($urandom_range(0, 3)), 28'($urandom())};
            cbv  = $urandom();
            send_cmd(word, cbv, -1);
            model_seq++;
            total_cnt++;
            if (obs_status !== exp_status(word, cbv, model_seq, 1'b0)) begin
                bad_cnt++;
                $display("FAIL ovr_clear[%0d]: got %h, required %h", t, obs_status,
                         exp_status(word, cbv, model_seq, 1'b0));
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] word;
        logic [31:0] cbv;
        int          tog2;
        int          lat;
        logic [3:0]  exp_en;
        for (int n = 0; n < 24; n++) begin
            word = $urandom();
            word[31:28] = 4'($urandom_range(0, 15));
            cbv  = $urandom();
            lat  = exp_latency(word);
            tog2 = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, lat - 1)) : -1;
            exp_en = (int'(word[31:28]) < NT) ? 4'(4'b0001 << word[31:28]) : 4'b0000;
            send_cmd(word, cbv, tog2);
            model_seq++;
            total_cnt++;
            if (obs_status !== exp_status(word, cbv, model_seq, tog2 >= 0)) begin
                bad_cnt++;
                $display("FAIL rnd_status[%0d]: word=%h got %h, required %h", n, word, obs_status,
                         exp_status(word, cbv, model_seq, tog2 >= 0));
            end
            total_cnt++;
            if (obs_done_k !== lat) begin
                bad_cnt++;
                $display("FAIL rnd_latency[%0d]: word=%h done at edge %0d, required %0d", n, word, obs_done_k, lat);
            end
            total_cnt++;
            if (obs_en_cnt !== ((exp_en != 4'b0000) ? 1 : 0) || obs_en_val !== exp_en) begin
                bad_cnt++;
                $display("FAIL rnd_enable[%0d]: word=%h pulses=%0d en=%b, required en=%b", n, word,
                         obs_en_cnt, obs_en_val, exp_en);
            end
            total_cnt++;
            if (obs_data_bad !== 0 || obs_status0[15] !== 1'b1 || obs_status0[11:8] !== word[31:28]) begin
                bad_cnt++;
                $display("FAIL rnd_accept[%0d]: data_bad=%0d status_after_accept=%h, required busy=1 opcode=%h",
                         n, obs_data_bad, obs_status0, word[31:28]);
            end
        end
    endtask

    task automatic test_seq_wrap();
        logic [31:0] word;
        logic [31:0] cbv;
        @(negedge clk);
        force dut.seq_r = 16'hFFFF;
        @(negedge clk);
        release dut.seq_r;
        model_seq = 16'hFFFF;
        word = 32'h2000_0077;
        cbv  = $urandom();
        send_cmd(word, cbv, -1);
        model_seq++;
        total_cnt++;
        if (obs_status[31:16] !== 16'h0000) begin
            bad_cnt++;
            $display("FAIL seq_wrap: seq=%h, required 0000", obs_status[31:16]);
        end
        total_cnt++;
        if (obs_status !== exp_status(word, cbv, model_seq, 1'b0)) begin
            bad_cnt++;
            $display("FAIL seq_wrap_status: got %h, required %h", obs_status,
                     exp_status(word, cbv, model_seq, 1'b0));
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] word;
        logic [31:0] cbv;
        int          errs;
        @(negedge clk);
        cmd_word   = 32'h1000_0055;
        callback   = $urandom();
        cmd_strobe = ~cmd_strobe;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        errs = 0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (en !== 4'b0000 || status !== 32'h0 || data !== 8'h00) errs++;
        end
        total_cnt++;
        if (errs !== 0) begin
            bad_cnt++;
            $display("FAIL reset_mid: %0d bad cycles (en=%b status=%h data=%h), required all zero",
                     errs, en, status, data);
        end
        model_seq = 16'd0;
        word = 32'h1000_00C3;
        cbv  = $urandom();
        send_cmd(word, cbv, -1);
        model_seq++;
        total_cnt++;
        if (obs_status !== exp_status(word, cbv, model_seq, 1'b0)) begin
            bad_cnt++;
            $display("FAIL reset_resume: got %h, required %h", obs_status,
                     exp_status(word, cbv, model_seq, 1'b0));
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        cmd_strobe = 1'b0;
        cmd_word   = 32'h0;
        callback   = 32'h0;
        model_seq  = 16'd0;
        test_reset();
        test_target0();
        test_target3();
        test_invalid();
        test_overrun();
        test_random();
        test_seq_wrap();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
